// File: rtl/sys_bridge_n.sv
// sys_bridge_n: CPU-to-peripheral bridge for the MIPS system bus.
// Decodes one CPU request into a one-hot device select, runs a registered
// request/acknowledge handshake with a bounded wait, and returns read data
// with a ready/error pulse. Also owns the interrupt mask and aggregates
// device interrupts into a single registered CPU interrupt.
module sys_bridge_n #(
    parameter int unsigned N_DEV   = 4,
    parameter logic [31:0] BASE    = 32'h0000_7f00,
    parameter int unsigned STRIDE  = 16,
    parameter int unsigned WIN     = 12,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [31:0]                 cpu_addr,
    input  logic [31:0]                 cpu_wdata,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_ready,
    output logic                        cpu_err,
    output logic [N_DEV-1:0]            dev_sel,
    output logic                        dev_we,
    output logic [$clog2(STRIDE)-3:0]   dev_addr,
    output logic [31:0]                 dev_wdata,
    input  logic [32*N_DEV-1:0]         dev_rdata,
    input  logic [N_DEV-1:0]            dev_ack,
    input  logic [N_DEV-1:0]            dev_irq,
    output logic                        irq_out
);

    localparam int unsigned SW        = $clog2(STRIDE);
    localparam int unsigned AW        = SW - 2;
    localparam int unsigned CW        = $clog2(TIMEOUT + 1);
    localparam logic [31:0] SPAN      = 32'(N_DEV * STRIDE);
    localparam logic [31:0] OFF_MASK  = 32'(STRIDE - 1);
    localparam logic [31:0] WIN_BYTES = 32'(WIN);
    localparam logic [31:0] CTRL_ADDR = BASE + SPAN;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_err_q, cpu_err_d;
    logic [N_DEV-1:0]  dev_sel_q, dev_sel_d;
    logic              dev_we_q, dev_we_d;
    logic [AW-1:0]     dev_addr_q, dev_addr_d;
    logic [31:0]       dev_wdata_q, dev_wdata_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [N_DEV-1:0]  irq_mask_q, irq_mask_d;
    logic [N_DEV-1:0]  irq_pending_q;
    logic              irq_out_q;

    logic [31:0]       off;
    logic              dev_hit;
    logic              ctrl_hit;
    logic              ack_hit;
    logic [31:0]       rdata_mux;

    // Offset wraps as unsigned, so addresses below BASE fall out of range.
    assign off      = cpu_addr - BASE;
    assign dev_hit  = (cpu_addr[1:0] == 2'b00) && (off < SPAN) && ((off & OFF_MASK) < WIN_BYTES);
    assign ctrl_hit = (cpu_addr == CTRL_ADDR);
    assign ack_hit  = |(dev_ack & dev_sel_q);

    // Read-data return mux driven by the held one-hot select.
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (dev_sel_q[i]) rdata_mux = dev_rdata[32*i +: 32];
        end
    end

    // Next-state and registered-output logic for the handshake FSM.
    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        cpu_err_d   = 1'b0;
        dev_sel_d   = dev_sel_q;
        dev_we_d    = dev_we_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        wait_cnt_d  = wait_cnt_q;
        irq_mask_d  = irq_mask_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (dev_hit) begin
                        state_d     = StAccess;
                        dev_sel_d   = N_DEV'(1) << (off >> SW);
                        dev_we_d    = cpu_we;
                        dev_addr_d  = off[SW-1:2];
                        dev_wdata_d = cpu_wdata;
                        wait_cnt_d  = '0;
                    end else if (ctrl_hit) begin
                        state_d     = StDone;
                        cpu_ready_d = 1'b1;
                        if (cpu_we) begin
                            irq_mask_d  = cpu_wdata[N_DEV-1:0];
                            cpu_rdata_d = '0;
                        end else begin
                            cpu_rdata_d = 32'(irq_mask_q);
                        end
                    end else begin
                        state_d     = StDone;
                        cpu_ready_d = 1'b1;
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = '0;
                    end
                end
            end
            StAccess: begin
                // An ack in the final wait cycle still wins over the timeout.
                if (ack_hit) begin
                    state_d     = StDone;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = dev_we_q ? 32'h0 : rdata_mux;
                    dev_sel_d   = '0;
                    dev_we_d    = 1'b0;
                end else if (wait_cnt_q == CNT_MAX) begin
                    state_d     = StDone;
                    cpu_ready_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = '0;
                    dev_sel_d   = '0;
                    dev_we_d    = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                dev_sel_d = '0;
                dev_we_d  = 1'b0;
            end
        endcase
    end

    // FSM state and all bus-facing outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            dev_sel_q   <= '0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            wait_cnt_q  <= '0;
            irq_mask_q  <= '1;
        end else begin
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            dev_sel_q   <= dev_sel_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            irq_mask_q  <= irq_mask_d;
        end
    end

    // Two-stage interrupt path: sample device lines, then mask and reduce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending_q <= '0;
            irq_out_q     <= 1'b0;
        end else begin
            irq_pending_q <= dev_irq;
            irq_out_q     <= |(irq_pending_q & irq_mask_q);
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign dev_sel   = dev_sel_q;
    assign dev_we    = dev_we_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;
    assign irq_out   = irq_out_q;

endmodule

// File: doc/sys_bridge_n.md
# sys_bridge_n

Parametrised CPU-to-peripheral bridge for the MIPS system bus, sitting between the CPU data-memory stage and N memory-mapped devices (timers and later peripherals). It decodes a single CPU request into a one-hot device select, runs a registered request/acknowledge handshake with a timeout, and returns read data with a ready/error response. It also holds a bridge-local interrupt mask register and aggregates the device interrupt lines into a single CPU interrupt.

## Interface
- N_DEV, 4: number of device windows (1..16).
- BASE, 32'h0000_7f00: byte address of device 0's window.
- STRIDE, 16: bytes per device window; power of two, at least 8.
- WIN, 12: decoded bytes at the start of each window; a multiple of 4 and no larger than STRIDE.
- TIMEOUT, 15: maximum wait cycles for dev_ack before an error response; at least 1.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ready is 1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  error flag, qualified by cpu_ready.
- dev_sel  out  N_DEV  one-hot device select, held for the whole access.
- dev_we  out  1  write enable to the selected device.
- dev_addr  out  log2(STRIDE)-2  word offset within the window.
- dev_wdata  out  32  write data to the devices.
- dev_rdata  in  32*N_DEV  flattened read buses; device i occupies bits [32i+31:32i].
- dev_ack  in  N_DEV  per-device acknowledge.
- dev_irq  in  N_DEV  level-sensitive device interrupts.
- irq_out  out  1  registered aggregate interrupt to the CPU.

## Operation
- Address decode:
  - off = cpu_addr - BASE, computed as a 32-bit unsigned value.
  - Device hit i = off/STRIDE, only if off < N_DEV*STRIDE, off%STRIDE < WIN and cpu_addr[1:0] == 0.
  - The control register CTRL sits at BASE + N_DEV*STRIDE. It is word-aligned and holds irq_mask in bits [N_DEV-1:0]; all other bits read as 0.
  - Every other address, including any misaligned one, is unmapped.
- FSM states:
  - IDLE: when cpu_req is 1, latch we, wdata and the decoded offset.
    - On a device hit, go to ACCESS.
    - On a CTRL access, write irq_mask if we is 1 (or capture it as read data), then go to DONE.
    - On an unmapped address, go to DONE with the error flag set.
  - ACCESS: dev_sel[i] = 1 and dev_we = latched we; dev_addr and dev_wdata are held stable.
    - dev_ack[i] = 1: capture dev_rdata slice i (0 for writes) and go to DONE.
    - The wait counter reaching TIMEOUT: go to DONE with the error flag set and rdata = 0.
    - Acks from non-selected devices are ignored.
  - DONE: cpu_ready = 1 and cpu_err = error flag for exactly one cycle, then IDLE. cpu_req is ignored in ACCESS and DONE.
- Wait counter:
  - Cleared on entry to ACCESS and incremented each ACCESS cycle without an ack.
  - Width is ceil(log2(TIMEOUT+1)); it never wraps.
  - If ack and the timeout occur in the same cycle, the ack wins (no error).
- Error responses: an errored write has no side effect; an errored read returns cpu_rdata = 0.
- Interrupts:
  - irq_pending <= dev_irq is registered every cycle.
  - irq_out <= |(irq_pending & irq_mask), giving two cycles from dev_irq to irq_out.
  - A CTRL mask write takes effect on irq_out two cycles after the request cycle.

## Timing
- Reset (asynchronous, immediate):
  - FSM returns to IDLE.
  - cpu_rdata, cpu_ready, cpu_err, dev_sel, dev_we, dev_addr, dev_wdata, irq_out and the wait counter all go to 0.
  - irq_mask goes to all ones.
- Reset during ACCESS drops dev_sel in the same cycle; the access is abandoned and no ready is produced.
- Latency, with the request in cycle T:
  - Unmapped or CTRL: cpu_ready in cycle T+1.
  - Device with ack in its first ACCESS cycle (T+1): cpu_ready in cycle T+2.
  - No ack: the error ready arrives in cycle T+2+TIMEOUT.
- dev_sel is asserted on at most one bit at a time, and only in ACCESS.
- cpu_rdata holds its value until the next DONE.

## Test plan
- Read device 1 at 32'h7f14; dev_ack[1] is 1 in the first ACCESS cycle with slice 1 = 32'hDEAD_BEEF.
  - Required: dev_sel = 4'b0010 and dev_addr = 1 for one cycle.
  - Required: cpu_ready in T+2 with cpu_rdata = DEADBEEF and cpu_err = 0.
- Write to 32'h7f0c (the gap within device 0's window) and to 32'h7f02 (misaligned).
  - Required: no dev_sel for either.
  - Required: cpu_ready with cpu_err = 1 in T+1 for each.
- Read 32'h7f20 with dev_ack held at 0 and TIMEOUT = 15.
  - Required: dev_sel[2] is asserted for 16 cycles.
  - Required: cpu_ready with cpu_err = 1 and rdata = 0 in T+17.
- Same as the previous case, but dev_ack[2] rises in the timeout cycle.
  - Required: cpu_err = 0.
- Write CTRL (32'h7f40) = 4'b0100, then raise dev_irq[1] and dev_irq[2].
  - Required: irq_out rises two cycles after dev_irq[2].
  - Required: reading CTRL returns 32'h4.
- Pulse reset_n low during ACCESS.
  - Required: dev_sel drops to 0 immediately and irq_mask returns to 4'hF.
  - Required: a following request completes normally.
